ext_unit: RTL and testbench

- Buffered, parametrised immediate-extension unit for the LC-3b datapath.
- Takes a raw instruction field (imm5, offset6, trapvect8, PCoffset9 or PCoffset11) and selects its width per transaction.
- Applies sign or zero extension to OUT_WIDTH, with an optional left-shift-by-1 (LSHF1).
- Delivers results in order through a DEPTH-entry FIFO with valid/ready handshakes on both sides; sits between decode and the address/ALU operand muxes.

---
 rtl/ext_unit.sv | 103 ++++++++++
 tb/tb_ext_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ext_unit.sv
// LC-3b immediate extension unit: sign/zero extend with optional LSHF1,
// results buffered in order through a small valid/ready FIFO.
module ext_unit #(
  parameter int IN_WIDTH  = 11,
  parameter int OUT_WIDTH = 16,
  parameter int DEPTH     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_WIDTH-1:0]        in_data,
  input  logic [2:0]                 in_sel,
  input  logic                       in_zext,
  input  logic                       in_lshf1,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_WIDTH-1:0]       out_data,
  output logic                       out_err,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [OUT_WIDTH-1:0] data_q [DEPTH];
  logic [OUT_WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]     err_q, err_d;
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;

  logic [OUT_WIDTH-1:0] ext;
  logic [OUT_WIDTH-1:0] res;
  logic                 bad;
  logic                 push, pop;

  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_data  = data_q[rptr_q];
  assign out_err   = err_q[rptr_q];
  assign count     = count_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    ext = '0;
    bad = 1'b0;
    case (in_sel)
      3'd0: ext = {{(OUT_WIDTH-5){~in_zext & in_data[4]}},
                   in_data[4:0]};
      3'd1: ext = {{(OUT_WIDTH-6){~in_zext & in_data[5]}},
                   in_data[5:0]};
      3'd2: ext = {{(OUT_WIDTH-8){~in_zext & in_data[7]}},
                   in_data[7:0]};
      3'd3: ext = {{(OUT_WIDTH-9){~in_zext & in_data[8]}},
                   in_data[8:0]};
      3'd4: ext = {{(OUT_WIDTH-11){~in_zext & in_data[10]}},
                   in_data[10:0]};
      default: bad = 1'b1;
    endcase
    res = in_lshf1 ? {ext[OUT_WIDTH-2:0], 1'b0} : ext;
  end

  always_comb begin
    data_d  = data_q;
    err_d   = err_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      data_d[wptr_q] = res;
      err_d[wptr_q]  = bad;
      wptr_d = (wptr_q == PW'(DEPTH-1)) ? '0 : wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = (rptr_q == PW'(DEPTH-1)) ? '0 : rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      err_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      err_q   <= err_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_ext_unit.sv
// Directed bench for ext_unit: vector table plus backpressure,
// streaming and mid-operation reset sequences.
module tb_ext_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] in_data = '0;
  logic [2:0]  in_sel = '0;
  logic        in_zext = 1'b0;
  logic        in_lshf1 = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_err;
  logic [1:0]  count;

  int checks = 0;
  int failures = 0;

  ext_unit #(.IN_WIDTH(11), .OUT_WIDTH(16), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel),
    .in_zext(in_zext), .in_lshf1(in_lshf1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic [10:0] data;
    logic        zext;
    logic        lshf1;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] s, input logic [10:0] d,
                       input logic z, input logic l);
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    in_zext  = z;
    in_lshf1 = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{3'd0, 11'h010, 1'b0, 1'b0, 16'hFFF0, 1'b0};
    vecs[1]  = '{3'd3, 11'h0FF, 1'b0, 1'b1, 16'h01FE, 1'b0};
    vecs[2]  = '{3'd3, 11'h100, 1'b0, 1'b1, 16'hFE00, 1'b0};
    vecs[3]  = '{3'd4, 11'h7FF, 1'b0, 1'b1, 16'hFFFE, 1'b0};
    vecs[4]  = '{3'd2, 11'h780, 1'b1, 1'b0, 16'h0080, 1'b0};
    vecs[5]  = '{3'd2, 11'h780, 1'b0, 1'b0, 16'hFF80, 1'b0};
    vecs[6]  = '{3'd1, 11'h020, 1'b0, 1'b0, 16'hFFE0, 1'b0};
    vecs[7]  = '{3'd1, 11'h01F, 1'b1, 1'b1, 16'h003E, 1'b0};
    vecs[8]  = '{3'd4, 11'h400, 1'b1, 1'b1, 16'h0800, 1'b0};
    vecs[9]  = '{3'd0, 11'h7EF, 1'b0, 1'b0, 16'h000F, 1'b0};
    vecs[10] = '{3'd6, 11'h7FF, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[11] = '{3'd5, 11'h123, 1'b0, 1'b1, 16'h0000, 1'b1};
    vecs[12] = '{3'd7, 11'h001, 1'b1, 1'b0, 16'h0000, 1'b1};

    // Reset state
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_err", 32'(out_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 1);

    // Vector table, one push then one pop each
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].sel, vecs[i].data, vecs[i].zext, vecs[i].lshf1);
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("v%0d_data", i), 32'(out_data),
          32'(vecs[i].exp_data));
      chk($sformatf("v%0d_err", i), 32'(out_err),
          32'(vecs[i].exp_err));
      chk($sformatf("v%0d_count1", i), 32'(count), 1);
      tick();
      chk($sformatf("v%0d_count0", i), 32'(count), 0);
      chk($sformatf("v%0d_empty", i), 32'(out_valid), 0);
    end

    // Backpressure: A, B fill the buffer, C is held off
    out_ready = 1'b0;
    drive(3'd0, 11'h001, 1'b0, 1'b0);
    tick();
    drive(3'd0, 11'h002, 1'b0, 1'b0);
    tick();
    drive(3'd0, 11'h003, 1'b0, 1'b0);
    chk("bp_count2", 32'(count), 2);
    chk("bp_in_ready0", 32'(in_ready), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp_hold_count%0d", k), 32'(count), 2);
      chk($sformatf("bp_hold_data%0d", k), 32'(out_data), 1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_pop_a_count", 32'(count), 1);
    chk("bp_head_b", 32'(out_data), 2);
    tick();
    in_valid = 1'b0;
    chk("bp_pushc_count", 32'(count), 1);
    chk("bp_head_c", 32'(out_data), 3);
    tick();
    chk("bp_drained", 32'(count), 0);

    // Illegal select then continuous streaming
    drive(3'd6, 11'h055, 1'b0, 1'b0);
    tick();
    chk("ill_count", 32'(count), 1);
    chk("ill_data", 32'(out_data), 0);
    chk("ill_err", 32'(out_err), 1);
    for (int k = 1; k <= 4; k++) begin
      drive(3'd0, 11'(k), 1'b0, 1'b0);
      tick();
      chk($sformatf("str_count%0d", k), 32'(count), 1);
      chk($sformatf("str_data%0d", k), 32'(out_data), k);
      chk($sformatf("str_err%0d", k), 32'(out_err), 0);
    end
    in_valid = 1'b0;
    tick();
    chk("str_drained", 32'(count), 0);

    // Reset mid-operation
    out_ready = 1'b0;
    drive(3'd0, 11'h005, 1'b0, 1'b0);
    tick();
    drive(3'd0, 11'h006, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("mr_full", 32'(count), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(out_valid), 0);
    chk("mr_count", 32'(count), 0);
    chk("mr_data", 32'(out_data), 0);
    chk("mr_err", 32'(out_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(3'd0, 11'h003, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("mr_new_valid", 32'(out_valid), 1);
    chk("mr_new_data", 32'(out_data), 3);
    tick();
    chk("mr_new_count", 32'(count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
